// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter sharing one Q5.11 signed multiplier (IDLE -> BUSY -> DONE).
// Define MULT_ARBITER_SAT_EN to saturate overflowing products; otherwise the product wraps.
module mult_arbiter #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic signed [DATA_W-1:0] a0,
  input  logic signed [DATA_W-1:0] b0,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] b1,
  output logic [1:0]               grant,
  output logic [1:0]               done,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state;
  logic                     prio_p0;
  logic                     win1_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic signed [DATA_W-1:0] prod_p1;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    ux = x;
    if (ux[DATA_W-1]) begin
      ux = ~ux;
      ux = ux + DATA_W'(1);
    end
    return ux;
  endfunction

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] nx;
    nx = ~x;
    nx = nx + DATA_W'(1);
    return nx;
  endfunction

  // Sign-magnitude multiply; truncation of the magnitude gives rounding toward zero.
  function automatic logic signed [DATA_W-1:0] q_mult(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    logic [DATA_W-1:0]   sh;
    logic                neg;
    p   = {{DATA_W{1'b0}}, mag(a)} * {{DATA_W{1'b0}}, mag(b)};
    sh  = p[FRAC_W+DATA_W-1:FRAC_W];
    neg = a[DATA_W-1] ^ b[DATA_W-1];
`ifdef MULT_ARBITER_SAT_EN
    return sat_apply(p[2*DATA_W-1:FRAC_W+DATA_W], sh, neg);
`else
    return neg ? negate(sh) : sh;
`endif
  endfunction

`ifdef MULT_ARBITER_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat_apply(input logic [DATA_W-FRAC_W-1:0] hi,
                                                         input logic [DATA_W-1:0] sh,
                                                         input logic neg);
    logic [DATA_W-1:0] min_neg;
    logic              ovf;
    min_neg = {1'b1, {(DATA_W-1){1'b0}}};
    ovf     = (hi != '0) || (neg ? (sh > min_neg) : sh[DATA_W-1]);
    if (ovf) return neg ? min_neg : {1'b0, {(DATA_W-1){1'b1}}};
    return neg ? negate(sh) : sh;
  endfunction
`endif

  // Tie goes to requester 1 only when requester 0 was served last.
  assign win1_p0 = req1 & (~req0 | prio_p0);

  // Stage p0: operand capture on the arbitration edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && (req0 || req1)) begin
      a_p0 <= win1_p0 ? a1 : a0;
      b_p0 <= win1_p0 ? b1 : b0;
    end
  end

  // Stage p1: product of the captured operands, registered into result in BUSY.
  assign prod_p1 = q_mult(a_p0, b_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      result  <= '0;
      prio_p0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          if (req0 || req1) begin
            grant <= win1_p0 ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          result <= prod_p1;
          done   <= grant;
          state  <= DONE;
        end
        DONE: begin
          done    <= 2'b00;
          prio_p0 <= grant[0];
          grant   <= 2'b00;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          done  <= 2'b00;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter; expectations follow MULT_ARBITER_SAT_EN when it is defined.
module tb_mult_arbiter;

  logic               clk;
  logic               rst;
  logic               req0, req1;
  logic signed [15:0] a0, b0, a1, b1;
  logic [1:0]         grant, done;
  logic signed [15:0] result;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  mult_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .grant(grant), .done(done), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One requester-0 operation: sample, BUSY, DONE, back to IDLE.
  task automatic op0(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp);
    req0 = 1'b1; a0 = a; b0 = b;
    step();
    chk({tag, "_grant"}, 16'(grant), 16'h0001);
    step();
    chk({tag, "_done"}, 16'(done), 16'h0001);
    chk({tag, "_result"}, result, exp);
    req0 = 1'b0;
    step();
    chk({tag, "_idle"}, {14'd0, busy, done[0]}, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step();
    step();
    chk("rst_grant", 16'(grant), 16'h0000);
    chk("rst_done", 16'(done), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_result", result, 16'h0000);

    // 1.0 x 1.0 on the first edge after reset release
    rst = 1'b0; req0 = 1'b1; a0 = 16'h0800; b0 = 16'h0800;
    step();
    chk("one_grant_c1", 16'(grant), 16'h0001);
    chk("one_busy_c1", 16'(busy), 16'h0001);
    chk("one_done_c1", 16'(done), 16'h0000);
    step();
    chk("one_grant_c2", 16'(grant), 16'h0001);
    chk("one_done_c2", 16'(done), 16'h0001);
    chk("one_result", result, 16'h0800);
    req0 = 1'b0;
    step();
    chk("one_done_c3", 16'(done), 16'h0000);
    chk("one_grant_c3", 16'(grant), 16'h0000);
    chk("one_busy_c3", 16'(busy), 16'h0000);
    chk("one_result_hold", result, 16'h0800);

    // 2.0 x -0.5 from requester 1, operands disturbed during BUSY
    req1 = 1'b1; a1 = 16'h1000; b1 = 16'hFC00;
    step();
    chk("r1_grant", 16'(grant), 16'h0002);
    a1 = 16'h7FFF; b1 = 16'h7FFF;
    step();
    chk("r1_done", 16'(done), 16'h0002);
    chk("r1_result", result, 16'hF800);
    req1 = 1'b0;
    step();
    chk("r1_idle", 16'(busy), 16'h0000);

    // Both requesting continuously: alternating service, one idle cycle between
    req0 = 1'b1; a0 = 16'h0800; b0 = 16'h1800;
    req1 = 1'b1; a1 = 16'hF800; b1 = 16'h0800;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d_grant", k), 16'(grant), (k % 2 == 0) ? 16'h0001 : 16'h0002);
      chk($sformatf("rr%0d_busy", k), 16'(busy), 16'h0001);
      step();
      chk($sformatf("rr%0d_done", k), 16'(done), (k % 2 == 0) ? 16'h0001 : 16'h0002);
      chk($sformatf("rr%0d_result", k), result, (k % 2 == 0) ? 16'h1800 : 16'hF800);
      step();
      chk($sformatf("rr%0d_gap", k), {14'd0, busy, |done}, 16'h0000);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Overflow, boundary and truncation cases
`ifdef MULT_ARBITER_SAT_EN
    op0("ovf_8x8", 16'h4000, 16'h4000, 16'h7FFF);
    op0("ovf_m16sq", 16'h8000, 16'h8000, 16'h7FFF);
    op0("ovf_neg", 16'h4000, 16'hC000, 16'h8000);
`else
    op0("ovf_8x8", 16'h4000, 16'h4000, 16'h0000);
    op0("ovf_m16sq", 16'h8000, 16'h8000, 16'h0000);
    op0("ovf_neg", 16'h4000, 16'hC000, 16'h0000);
`endif
    op0("min_neg", 16'h8000, 16'h0800, 16'h8000);
    op0("zero_neg", 16'h0000, 16'hF800, 16'h0000);
    op0("trunc_zero", 16'hFFFF, 16'h0400, 16'h0000);
    op0("neg_x_neg", 16'hF000, 16'hFC00, 16'h0800);

    // Operand change and req drop during BUSY
    req0 = 1'b1; a0 = 16'h1000; b0 = 16'h1000;
    step();
    a0 = 16'h0800; b0 = 16'h0800; req0 = 1'b0;
    step();
    chk("latch_done", 16'(done), 16'h0001);
    chk("latch_result", result, 16'h2000);
    step();

    // Reset during BUSY discards the operation and restores the tie pointer
    req1 = 1'b1; a1 = 16'h0800; b1 = 16'h0800;
    step();
    chk("mid_grant", 16'(grant), 16'h0002);
    rst = 1'b1; req1 = 1'b0;
    step();
    chk("mid_rst_grant", 16'(grant), 16'h0000);
    chk("mid_rst_busy", 16'(busy), 16'h0000);
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_done", 16'(done), 16'h0000);
    rst = 1'b0;
    step();
    chk("mid_no_done", 16'(done), 16'h0000);
    req0 = 1'b1; req1 = 1'b1; a0 = 16'h0800; b0 = 16'h2000;
    step();
    chk("post_rst_tie", 16'(grant), 16'h0001);
    step();
    chk("post_rst_done", 16'(done), 16'h0001);
    chk("post_rst_result", result, 16'h2000);
    req0 = 1'b0; req1 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
